// File: rtl/line_presence_tracker.sv
// Purpose: tracks DEPTH I-cache line buffers and answers "here / will be here" for the fetch PC.
// Latency: lookup is combinational on registered state; buffer state, request and counter update next edge.
// Backpressure: request held until req_ready_i; a miss while the request is stalled or all buffers are busy is dropped.
module line_presence_tracker #(
   parameter int XLEN     = 32,
   parameter int LINE_OFF = 4,
   parameter int DEPTH    = 4
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       flush_i,
   input  logic                       lookup_valid_i,
   input  logic [XLEN-1:0]            pc_i,
   output logic                       here_o,
   output logic                       will_be_here_o,
   output logic                       miss_o,
   output logic [$clog2(DEPTH)-1:0]   hit_idx_o,
   output logic                       req_valid_o,
   output logic [XLEN-1:0]            req_addr_o,
   input  logic                       req_ready_i,
   input  logic                       rsp_valid_i,
   output logic [$clog2(DEPTH)-1:0]   fill_idx_o,
   output logic [$clog2(DEPTH):0]     pending_cnt_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int TAG_W = XLEN - LINE_OFF;

   typedef enum logic [1:0] {
      ST_INVALID = 2'd0,
      ST_PENDING = 2'd1,
      ST_VALID   = 2'd2,
      ST_STALE   = 2'd3
   } line_state_e;

   line_state_e        state_q [DEPTH];
   line_state_e        state_d [DEPTH];
   logic [TAG_W-1:0]   tag_q   [DEPTH];
   logic [TAG_W-1:0]   tag_d   [DEPTH];
   logic [PTR_W-1:0]   alloc_ptr_q, alloc_ptr_d;
   logic [PTR_W-1:0]   fill_ptr_q, fill_ptr_d;
   logic               req_valid_q, req_valid_d;
   logic [XLEN-1:0]    req_addr_q, req_addr_d;
   logic [CNT_W-1:0]   pending_cnt_q, pending_cnt_d;

   logic [TAG_W-1:0]   pc_tag;
   logic               valid_hit;
   logic               pend_hit;
   logic [PTR_W-1:0]   hit_idx;
   logic               alloc_ok;
   logic               fill_ok;
   logic               unused_pc_off;

   assign pc_tag        = pc_i[XLEN-1:LINE_OFF];
   // Byte offset within the line plays no part in presence.
   assign unused_pc_off = ^pc_i[LINE_OFF-1:0];

   // Tag match across all buffers; the lowest matching VALID/PENDING index wins.
   always_comb begin
      valid_hit = 1'b0;
      pend_hit  = 1'b0;
      hit_idx   = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (tag_q[i] == pc_tag) begin
            if (state_q[i] == ST_VALID) begin
               valid_hit = 1'b1;
               if (lookup_valid_i) hit_idx = PTR_W'(i);
            end else if (state_q[i] == ST_PENDING) begin
               pend_hit = 1'b1;
               if (lookup_valid_i) hit_idx = PTR_W'(i);
            end
         end
      end
   end

   assign here_o         = lookup_valid_i & valid_hit;
   assign will_be_here_o = lookup_valid_i & ~valid_hit & pend_hit;
   assign miss_o         = lookup_valid_i & ~valid_hit & ~pend_hit;
   assign hit_idx_o      = hit_idx;

   // Allocation needs a free slot for the request register and a non-busy victim buffer.
   assign alloc_ok = miss_o & ~flush_i & (~req_valid_q | req_ready_i) &
                     ((state_q[alloc_ptr_q] == ST_INVALID) | (state_q[alloc_ptr_q] == ST_VALID));

   // A response only consumes a fill slot when the head buffer is actually in flight.
   assign fill_ok = rsp_valid_i &
                    ((state_q[fill_ptr_q] == ST_PENDING) | (state_q[fill_ptr_q] == ST_STALE));

   // Per-buffer next state: flush first, then fill, then alloc (fill and alloc never share a buffer).
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         state_d[i] = state_q[i];
         tag_d[i]   = tag_q[i];
         if (flush_i) begin
            if (state_q[i] == ST_VALID)   state_d[i] = ST_INVALID;
            if (state_q[i] == ST_PENDING) state_d[i] = ST_STALE;
         end
         if (fill_ok && (PTR_W'(i) == fill_ptr_q)) begin
            state_d[i] = ((state_q[i] == ST_PENDING) && !flush_i) ? ST_VALID : ST_INVALID;
         end
         if (alloc_ok && (PTR_W'(i) == alloc_ptr_q)) begin
            state_d[i] = ST_PENDING;
            tag_d[i]   = pc_tag;
         end
      end
   end

   // Pointers, request register and in-flight counter.
   always_comb begin
      alloc_ptr_d   = alloc_ok ? alloc_ptr_q + PTR_W'(1) : alloc_ptr_q;
      fill_ptr_d    = fill_ok  ? fill_ptr_q  + PTR_W'(1) : fill_ptr_q;
      req_valid_d   = req_valid_q;
      req_addr_d    = req_addr_q;
      pending_cnt_d = pending_cnt_q;
      if (alloc_ok) begin
         req_valid_d = 1'b1;
         req_addr_d  = {pc_tag, {LINE_OFF{1'b0}}};
      end else if (req_ready_i) begin
         req_valid_d = 1'b0;
      end
      if (alloc_ok && !fill_ok) pending_cnt_d = pending_cnt_q + CNT_W'(1);
      if (!alloc_ok && fill_ok) pending_cnt_d = pending_cnt_q - CNT_W'(1);
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            state_q[i] <= ST_INVALID;
            tag_q[i]   <= '0;
         end
         alloc_ptr_q   <= '0;
         fill_ptr_q    <= '0;
         req_valid_q   <= 1'b0;
         req_addr_q    <= '0;
         pending_cnt_q <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            state_q[i] <= state_d[i];
            tag_q[i]   <= tag_d[i];
         end
         alloc_ptr_q   <= alloc_ptr_d;
         fill_ptr_q    <= fill_ptr_d;
         req_valid_q   <= req_valid_d;
         req_addr_q    <= req_addr_d;
         pending_cnt_q <= pending_cnt_d;
      end
   end

   assign req_valid_o   = req_valid_q;
   assign req_addr_o    = req_addr_q;
   assign fill_idx_o    = fill_ptr_q;
   assign pending_cnt_o = pending_cnt_q;

endmodule

// File: tb/tb_line_presence_tracker.sv
// Bench for line_presence_tracker: directed scenarios then randomized traffic against a reference model.
// Latency: outputs sampled 1-2 time units after the rising edge.
// Backpressure: req_ready_i and rsp_valid_i driven directly by the bench.
module tb_line_presence_tracker;

   localparam int XLEN     = 32;
   localparam int LINE_OFF = 4;
   localparam int DEPTH    = 4;

   localparam int S_INV   = 0;
   localparam int S_PEND  = 1;
   localparam int S_VAL   = 2;
   localparam int S_STALE = 3;

   logic              clk = 1'b0;
   logic              rst, flush, lookup_valid, req_ready, rsp_valid;
   logic [XLEN-1:0]   pc;
   logic              here, will_be_here, miss, req_valid;
   logic [1:0]        hit_idx, fill_idx;
   logic [XLEN-1:0]   req_addr;
   logic [2:0]        pending_cnt;

   int checks = 0;
   int errors = 0;

   // Reference model: one entry per buffer, plus request register and two ring pointers.
   int              m_state [DEPTH];
   logic [XLEN-1:0] m_line  [DEPTH];
   int              m_alloc, m_fill;
   logic            m_req_v;
   logic [XLEN-1:0] m_req_a;
   logic            e_here, e_will, e_miss;
   int              e_hit;

   always #5 clk = ~clk;

   line_presence_tracker #(.XLEN(XLEN), .LINE_OFF(LINE_OFF), .DEPTH(DEPTH)) dut (
      .clk_i(clk), .rst_i(rst), .flush_i(flush), .lookup_valid_i(lookup_valid), .pc_i(pc),
      .here_o(here), .will_be_here_o(will_be_here), .miss_o(miss), .hit_idx_o(hit_idx),
      .req_valid_o(req_valid), .req_addr_o(req_addr), .req_ready_i(req_ready),
      .rsp_valid_i(rsp_valid), .fill_idx_o(fill_idx), .pending_cnt_o(pending_cnt)
   );

   function automatic logic [XLEN-1:0] line_of(input logic [XLEN-1:0] a);
      return (a >> LINE_OFF) << LINE_OFF;
   endfunction

   function automatic int model_inflight();
      int n = 0;
      for (int i = 0; i < DEPTH; i++)
         if (m_state[i] == S_PEND || m_state[i] == S_STALE) n++;
      return n;
   endfunction

   task automatic model_predict();
      bit found_v = 0, found_p = 0, found = 0;
      e_hit = 0;
      for (int i = 0; i < DEPTH; i++) begin
         if (m_line[i] == line_of(pc) && (m_state[i] == S_VAL || m_state[i] == S_PEND)) begin
            if (m_state[i] == S_VAL) found_v = 1; else found_p = 1;
            if (!found) e_hit = i;
            found = 1;
         end
      end
      e_here = lookup_valid && found_v;
      e_will = lookup_valid && !found_v && found_p;
      e_miss = lookup_valid && !found;
      if (!lookup_valid) e_hit = 0;
   endtask

   task automatic model_step();
      int  old_state [DEPTH];
      bit  do_alloc, do_fill;
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin m_state[i] = S_INV; m_line[i] = '0; end
         m_alloc = 0; m_fill = 0; m_req_v = 0; m_req_a = '0;
         return;
      end
      model_predict();
      old_state = m_state;
      do_alloc = e_miss && !flush && (!m_req_v || req_ready) &&
                 (old_state[m_alloc] == S_INV || old_state[m_alloc] == S_VAL);
      do_fill  = rsp_valid && (old_state[m_fill] == S_PEND || old_state[m_fill] == S_STALE);
      if (flush)
         for (int i = 0; i < DEPTH; i++) begin
            if (old_state[i] == S_VAL)  m_state[i] = S_INV;
            if (old_state[i] == S_PEND) m_state[i] = S_STALE;
         end
      if (do_fill) begin
         m_state[m_fill] = (old_state[m_fill] == S_PEND && !flush) ? S_VAL : S_INV;
         m_fill = (m_fill + 1) % DEPTH;
      end
      if (do_alloc) begin
         m_state[m_alloc] = S_PEND;
         m_line[m_alloc]  = line_of(pc);
         m_alloc = (m_alloc + 1) % DEPTH;
         m_req_v = 1;
         m_req_a = line_of(pc);
      end else if (req_ready) begin
         m_req_v = 0;
      end
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      rst = 0; flush = 0; lookup_valid = 0; pc = '0; req_ready = 0; rsp_valid = 0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1;
      tick();
      tick();
      rst = 0;
   endtask

   task automatic query(input logic [XLEN-1:0] a);
      lookup_valid = 1; pc = a; #1;
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      checks++; if (here !== 1'b0) begin errors++; $display("FAIL rst_here got=%b want=0", here); end
      checks++; if (will_be_here !== 1'b0) begin errors++; $display("FAIL rst_will got=%b want=0", will_be_here); end
      checks++; if (miss !== 1'b0) begin errors++; $display("FAIL rst_miss got=%b want=0", miss); end
      checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL rst_req_valid got=%b want=0", req_valid); end
      checks++; if (req_addr !== 32'h0) begin errors++; $display("FAIL rst_req_addr got=%h want=0", req_addr); end
      checks++; if (pending_cnt !== 3'd0) begin errors++; $display("FAIL rst_pending got=%0d want=0", pending_cnt); end
      checks++; if (fill_idx !== 2'd0) begin errors++; $display("FAIL rst_fill_idx got=%0d want=0", fill_idx); end
   endtask

   task automatic test_alloc();
      query(32'h1000);
      checks++; if (miss !== 1'b1) begin errors++; $display("FAIL alloc_miss got=%b want=1", miss); end
      checks++; if (hit_idx !== 2'd0) begin errors++; $display("FAIL alloc_miss_idx got=%0d want=0", hit_idx); end
      tick();
      #1;
      checks++; if (req_valid !== 1'b1) begin errors++; $display("FAIL alloc_req_valid got=%b want=1", req_valid); end
      checks++; if (req_addr !== 32'h1000) begin errors++; $display("FAIL alloc_req_addr got=%h want=1000", req_addr); end
      checks++; if (will_be_here !== 1'b1) begin errors++; $display("FAIL alloc_will got=%b want=1", will_be_here); end
      checks++; if (hit_idx !== 2'd0) begin errors++; $display("FAIL alloc_idx got=%0d want=0", hit_idx); end
      checks++; if (pending_cnt !== 3'd1) begin errors++; $display("FAIL alloc_pending got=%0d want=1", pending_cnt); end
   endtask

   task automatic test_backpressure();
      lookup_valid = 0; req_ready = 0;
      for (int k = 0; k < 3; k++) tick();
      query(32'h2000);
      checks++; if (miss !== 1'b1) begin errors++; $display("FAIL bp_miss got=%b want=1", miss); end
      tick();
      #1;
      checks++; if (req_addr !== 32'h1000) begin errors++; $display("FAIL bp_hold_addr got=%h want=1000", req_addr); end
      checks++; if (miss !== 1'b1) begin errors++; $display("FAIL bp_no_alloc got=%b want=1", miss); end
      checks++; if (pending_cnt !== 3'd1) begin errors++; $display("FAIL bp_pending got=%0d want=1", pending_cnt); end
      req_ready = 1;
      tick();
      req_ready = 0;
      #1;
      checks++; if (req_valid !== 1'b1) begin errors++; $display("FAIL b2b_req_valid got=%b want=1", req_valid); end
      checks++; if (req_addr !== 32'h2000) begin errors++; $display("FAIL b2b_req_addr got=%h want=2000", req_addr); end
      checks++; if (will_be_here !== 1'b1) begin errors++; $display("FAIL b2b_will got=%b want=1", will_be_here); end
      checks++; if (hit_idx !== 2'd1) begin errors++; $display("FAIL b2b_idx got=%0d want=1", hit_idx); end
      checks++; if (pending_cnt !== 3'd2) begin errors++; $display("FAIL b2b_pending got=%0d want=2", pending_cnt); end
   endtask

   task automatic test_fill();
      lookup_valid = 0; req_ready = 1;
      tick();
      req_ready = 0;
      #1;
      checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL fill_req_drop got=%b want=0", req_valid); end
      rsp_valid = 1;
      query(32'h1000);
      checks++; if (fill_idx !== 2'd0) begin errors++; $display("FAIL fill_idx got=%0d want=0", fill_idx); end
      checks++; if (will_be_here !== 1'b1) begin errors++; $display("FAIL fill_cycle_will got=%b want=1", will_be_here); end
      tick();
      rsp_valid = 0;
      query(32'h100C);
      checks++; if (here !== 1'b1) begin errors++; $display("FAIL fill_here got=%b want=1", here); end
      checks++; if (hit_idx !== 2'd0) begin errors++; $display("FAIL fill_hit_idx got=%0d want=0", hit_idx); end
      checks++; if (pending_cnt !== 3'd1) begin errors++; $display("FAIL fill_pending got=%0d want=1", pending_cnt); end
      lookup_valid = 0; rsp_valid = 1;
      tick();
      rsp_valid = 0;
      #1;
      checks++; if (pending_cnt !== 3'd0) begin errors++; $display("FAIL fill2_pending got=%0d want=0", pending_cnt); end
   endtask

   task automatic test_replace();
      logic [XLEN-1:0] lines [4];
      lines[0] = 32'h00; lines[1] = 32'h10; lines[2] = 32'h20; lines[3] = 32'h30;
      do_reset();
      req_ready = 1;
      for (int k = 0; k < 4; k++) begin
         lookup_valid = 1; pc = lines[k];
         tick();
      end
      lookup_valid = 0; rsp_valid = 1;
      for (int k = 0; k < 4; k++) tick();
      rsp_valid = 0;
      #1;
      checks++; if (pending_cnt !== 3'd0) begin errors++; $display("FAIL rep_pending got=%0d want=0", pending_cnt); end
      for (int k = 0; k < 4; k++) begin
         query(lines[k] + 32'h4);
         checks++; if (here !== 1'b1 || hit_idx !== 2'(k)) begin
            errors++; $display("FAIL rep_here%0d got=%b/%0d want=1/%0d", k, here, hit_idx, k); end
      end
      query(32'h40);
      checks++; if (miss !== 1'b1) begin errors++; $display("FAIL rep_miss40 got=%b want=1", miss); end
      tick();
      query(32'h0);
      checks++; if (miss !== 1'b1) begin errors++; $display("FAIL rep_victim got=%b want=1", miss); end
      query(32'h40);
      checks++; if (will_be_here !== 1'b1 || hit_idx !== 2'd0) begin
         errors++; $display("FAIL rep_new got=%b/%0d want=1/0", will_be_here, hit_idx); end
      lookup_valid = 0; rsp_valid = 1;
      tick();
      rsp_valid = 0;
   endtask

   task automatic test_flush();
      req_ready = 1;
      lookup_valid = 1; pc = 32'h100; tick();
      pc = 32'h110; tick();
      lookup_valid = 0; req_ready = 0; flush = 1;
      tick();
      flush = 0;
      #1;
      checks++; if (req_valid !== 1'b1 || req_addr !== 32'h110) begin
         errors++; $display("FAIL fl_req_hold got=%b/%h want=1/110", req_valid, req_addr); end
      checks++; if (pending_cnt !== 3'd2) begin errors++; $display("FAIL fl_pending got=%0d want=2", pending_cnt); end
      query(32'h110);
      checks++; if (miss !== 1'b1) begin errors++; $display("FAIL fl_stale_miss got=%b want=1", miss); end
      lookup_valid = 0; req_ready = 1; rsp_valid = 1;
      tick();
      tick();
      rsp_valid = 0;
      #1;
      checks++; if (pending_cnt !== 3'd0) begin errors++; $display("FAIL fl_pending_end got=%0d want=0", pending_cnt); end
      checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL fl_req_end got=%b want=0", req_valid); end
      query(32'h100);
      checks++; if (here !== 1'b0 || miss !== 1'b1) begin errors++; $display("FAIL fl_100 got=%b/%b want=0/1", here, miss); end
      query(32'h110);
      checks++; if (here !== 1'b0 || miss !== 1'b1) begin errors++; $display("FAIL fl_110 got=%b/%b want=0/1", here, miss); end
      query(32'h40);
      checks++; if (miss !== 1'b1) begin errors++; $display("FAIL fl_valid_inval got=%b want=1", miss); end
      lookup_valid = 0;
   endtask

   task automatic test_full();
      req_ready = 1;
      for (int k = 0; k < 4; k++) begin
         lookup_valid = 1; pc = 32'h200 + 32'(k * 16);
         tick();
      end
      lookup_valid = 0;
      tick();
      #1;
      checks++; if (pending_cnt !== 3'd4) begin errors++; $display("FAIL full_pending got=%0d want=4", pending_cnt); end
      query(32'h80);
      checks++; if (miss !== 1'b1) begin errors++; $display("FAIL full_miss got=%b want=1", miss); end
      tick();
      #1;
      checks++; if (req_valid !== 1'b0 || pending_cnt !== 3'd4 || miss !== 1'b1) begin
         errors++; $display("FAIL full_no_alloc got=%b/%0d/%b want=0/4/1", req_valid, pending_cnt, miss); end
      rsp_valid = 1;
      #1;
      checks++; if (fill_idx !== 2'd3) begin errors++; $display("FAIL full_fill_idx got=%0d want=3", fill_idx); end
      tick();
      rsp_valid = 0;
      tick();
      #1;
      checks++; if (will_be_here !== 1'b1 || hit_idx !== 2'd3) begin
         errors++; $display("FAIL full_realloc got=%b/%0d want=1/3", will_be_here, hit_idx); end
      checks++; if (req_valid !== 1'b1 || req_addr !== 32'h80) begin
         errors++; $display("FAIL full_req got=%b/%h want=1/80", req_valid, req_addr); end
      checks++; if (pending_cnt !== 3'd4) begin errors++; $display("FAIL full_pending2 got=%0d want=4", pending_cnt); end
      query(32'h200);
      checks++; if (miss !== 1'b1) begin errors++; $display("FAIL full_victim got=%b want=1", miss); end
      lookup_valid = 0;
      tick();
   endtask

   task automatic test_random();
      for (int n = 0; n < 600; n++) begin
         rst          = ($urandom_range(0, 299) == 0);
         flush        = ($urandom_range(0, 24) == 0);
         lookup_valid = ($urandom_range(0, 3) != 0);
         pc           = (32'($urandom_range(0, 7)) << LINE_OFF) | 32'($urandom_range(0, 15));
         req_ready    = $urandom_range(0, 1);
         rsp_valid    = ($urandom_range(0, 9) < 4);
         #1;
         model_predict();
         if (lookup_valid) begin
            checks++; if (here !== e_here) begin errors++; $display("FAIL rnd_here n=%0d got=%b want=%b", n, here, e_here); end
            checks++; if (will_be_here !== e_will) begin errors++; $display("FAIL rnd_will n=%0d got=%b want=%b", n, will_be_here, e_will); end
            checks++; if (miss !== e_miss) begin errors++; $display("FAIL rnd_miss n=%0d got=%b want=%b", n, miss, e_miss); end
            checks++; if (hit_idx !== 2'(e_hit)) begin errors++; $display("FAIL rnd_hit_idx n=%0d got=%0d want=%0d", n, hit_idx, e_hit); end
         end
         checks++; if (req_valid !== m_req_v) begin errors++; $display("FAIL rnd_req_valid n=%0d got=%b want=%b", n, req_valid, m_req_v); end
         checks++; if (req_addr !== m_req_a) begin errors++; $display("FAIL rnd_req_addr n=%0d got=%h want=%h", n, req_addr, m_req_a); end
         checks++; if (fill_idx !== 2'(m_fill)) begin errors++; $display("FAIL rnd_fill_idx n=%0d got=%0d want=%0d", n, fill_idx, m_fill); end
         checks++; if (pending_cnt !== 3'(model_inflight())) begin
            errors++; $display("FAIL rnd_pending n=%0d got=%0d want=%0d", n, pending_cnt, model_inflight()); end
         tick();
      end
      idle_inputs();
   endtask

   initial begin
      idle_inputs();
      for (int i = 0; i < DEPTH; i++) begin m_state[i] = S_INV; m_line[i] = '0; end
      m_alloc = 0; m_fill = 0; m_req_v = 0; m_req_a = '0;
      #1;
      test_reset();
      test_alloc();
      test_backpressure();
      test_fill();
      test_replace();
      test_flush();
      test_full();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/line_presence_tracker.md
Name: line_presence_tracker

Overview:
- Multi-line successor to the single-line presence check in the fetch front-end.
- Tracks DEPTH instruction-cache line buffers; each buffer holds a tag and a state of INVALID, PENDING, VALID or STALE.
- Answers per-cycle "line is here" / "line will be here" queries for the fetch PC.
- On a miss, allocates a buffer in round-robin order and issues one line request with a valid/ready handshake. Responses return in order and are matched to buffers with a FIFO fill pointer.

Parameters:
- XLEN, 32, address width (matches mmm_pkg XLEN).
- LINE_OFF, 4, byte-offset bits per line (tag = addr[XLEN-1:LINE_OFF]); set equal to ICACHE_OFFSET+OFFSET at instantiation.
- DEPTH, 4, number of line buffers; power of 2, at least 2.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- flush_i  in  1  invalidate all lines (branch redirect / fence.i)
- lookup_valid_i  in  1  pc_i is a live query this cycle
- pc_i  in  XLEN  fetch PC
- here_o  out  1  PC's line is VALID in a buffer
- will_be_here_o  out  1  PC's line is PENDING (in flight)
- miss_o  out  1  live query, no VALID or PENDING match
- hit_idx_o  out  $clog2(DEPTH)  buffer index of the match (VALID or PENDING); 0 when no match
- req_valid_o  out  1  line request valid
- req_addr_o  out  XLEN  line-aligned request address (low LINE_OFF bits zero)
- req_ready_i  in  1  memory accepts request
- rsp_valid_i  in  1  in-order line response arrives
- fill_idx_o  out  $clog2(DEPTH)  buffer written by the current response (= fill_ptr)
- pending_cnt_o  out  $clog2(DEPTH)+1  number of PENDING+STALE buffers

Behaviour:
- Reset (rst_i=1 at a clk_i edge; overrides all other inputs that cycle):
  - All buffers INVALID; alloc_ptr=0, fill_ptr=0.
  - req_valid_o=0, req_addr_o=0, pending_cnt_o=0.
  - here_o, will_be_here_o and miss_o are all 0 because they are gated by lookup_valid_i.
- Lookup is combinational on registered state, with zero latency:
  - here_o = lookup_valid_i & any VALID tag match.
  - will_be_here_o = lookup_valid_i & !here_o & any PENDING tag match.
  - miss_o = lookup_valid_i & !here_o & !will_be_here_o.
  - STALE and INVALID buffers never match.
  - Under the allocation rules a tag appears in at most one VALID/PENDING buffer.
  - hit_idx_o is the lowest matching index.
- Allocation:
  - alloc_ok = miss_o & !flush_i & (!req_valid_o | req_ready_i) & state[alloc_ptr] is INVALID or VALID. The VALID victim is overwritten.
  - When alloc_ok: buffer[alloc_ptr] becomes PENDING with the PC's tag; the request register loads with req_valid_o=1 and req_addr_o={tag, LINE_OFF'b0}; alloc_ptr increments modulo DEPTH.
  - The same PC queried next cycle returns will_be_here_o=1.
  - A miss while alloc_ok=0 is dropped silently; fetch re-queries.
- Request handshake:
  - req_valid_o and req_addr_o are held stable until req_ready_i=1.
  - On acceptance without a new alloc, req_valid_o falls to 0 the next cycle.
  - Accept and new alloc in the same cycle keeps req_valid_o=1 and loads the new address (back-to-back).
- Response:
  - rsp_valid_i with state[fill_ptr]=PENDING moves the buffer to VALID.
  - rsp_valid_i with state[fill_ptr]=STALE moves the buffer to INVALID.
  - In both cases fill_ptr increments modulo DEPTH.
  - rsp_valid_i with state[fill_ptr] INVALID or VALID is a protocol violation: it is ignored and fill_ptr is held.
  - A lookup in the fill cycle still sees PENDING; here_o asserts the following cycle.
- Flush, applied at the edge:
  - VALID becomes INVALID, and PENDING becomes STALE.
  - An issued but unaccepted request stays asserted until accepted, because its response still consumes a fill slot.
  - Pointers are unchanged, and allocation is suppressed in the flush cycle.
  - A response in the same cycle as the flush still advances fill_ptr and leaves that buffer INVALID.
- Simultaneous alloc and fill never target the same buffer, since alloc requires a non-PENDING, non-STALE buffer and fill requires PENDING or STALE.
- pending_cnt_o = (number of allocs) − (number of valid fills); it is registered and ranges 0..DEPTH.
- When all buffers are PENDING/STALE, alloc_ok=0. This is the full condition.
- Both pointers wrap from DEPTH-1 to 0.

Test Plan:
- Reset, then lookup pc_i=0x1000 -> miss_o=1 and hit_idx_o=0. Next cycle: req_valid_o=1, req_addr_o=0x1000, will_be_here_o=1, hit_idx_o=0, pending_cnt_o=1.
- Hold req_ready_i=0 for 3 cycles, then lookup 0x2000 -> req_addr_o stays 0x1000 and no alloc occurs. Pulse req_ready_i and re-query -> second request 0x2000 at index 1.
- rsp_valid_i for 0x1000 -> fill_idx_o=0. Next cycle lookup 0x100C -> here_o=1, hit_idx_o=0, pending_cnt_o decrements.
- DEPTH=4: fill all 4 lines (0x0, 0x10, 0x20, 0x30), then miss on 0x40 -> buffer 0 replaced. Next cycle, lookup 0x0 -> miss_o=1.
- Two requests in flight, flush_i=1, then two responses -> no here_o for either address, both buffers INVALID, pending_cnt_o returns to 0.
- 4 outstanding requests with no responses, then miss on 0x80 -> req_valid_o unchanged and no alloc. One response -> alloc for 0x80 succeeds at the buffer just filled.
